// File: rtl/iir_capture.sv
// rtl/iir_capture.sv - impulse-response capture engine: flush, impulse, capture, drain
module iir_capture #(
  parameter int DEPTH = 128,
  parameter int FLUSH = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [15:0] IMP_AMP,
  output logic [15:0] STIM,
  input  logic [15:0] RESP,
  output logic [15:0] DOUT,
  output logic        DVALID,
  input  logic        DREADY,
  output logic        DLAST,
  output logic        BUSY,
  output logic        DONE,
  output logic        SAT
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] DEPTH_LAST = AW'(DEPTH - 1);
  localparam logic [7:0]    FLUSH_LAST = 8'(FLUSH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_IMPULSE,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  state_t        state_q;
  logic [15:0]   amp_q;
  logic [7:0]    cnt_q;
  logic [AW-1:0] wr_idx_q;
  logic [AW-1:0] rd_idx_q;
  logic [15:0]   stim_q;
  logic [15:0]   dout_q;
  logic          dvalid_q;
  logic          dlast_q;
  logic          done_q;
  logic          sat_q;

  logic [15:0]   mem [DEPTH];
  logic          wr_en;
  logic          resp_extreme;

  // The impulse cycle itself is capture slot 0, so writing spans IMPULSE and CAPTURE.
  assign wr_en        = (state_q == S_IMPULSE) || (state_q == S_CAPTURE);
  assign resp_extreme = (RESP == 16'h7FFF) || (RESP == 16'h8000);

  // Sample buffer; contents are never reset, DVALID gating keeps stale data hidden.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_idx_q] <= RESP;
    end
  end

  // Run sequencer with registered stimulus, readout and status outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      amp_q    <= 16'h0000;
      cnt_q    <= 8'd0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      stim_q   <= 16'h0000;
      dout_q   <= 16'h0000;
      dvalid_q <= 1'b0;
      dlast_q  <= 1'b0;
      done_q   <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            amp_q    <= IMP_AMP;
            sat_q    <= 1'b0;
            cnt_q    <= 8'd0;
            wr_idx_q <= '0;
            state_q  <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (cnt_q == FLUSH_LAST) begin
            stim_q  <= amp_q;
            state_q <= S_IMPULSE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_IMPULSE: begin
          stim_q   <= 16'h0000;
          wr_idx_q <= wr_idx_q + AW'(1);
          state_q  <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (wr_idx_q == DEPTH_LAST) begin
            rd_idx_q <= '0;
            state_q  <= S_DRAIN;
          end else begin
            wr_idx_q <= wr_idx_q + AW'(1);
          end
        end
        S_DRAIN: begin
          // Output register is reloaded when empty or when its beat is taken,
          // which gives back-to-back beats and a frozen beat while stalled.
          if (!dvalid_q || DREADY) begin
            if (dvalid_q && dlast_q) begin
              dvalid_q <= 1'b0;
              dlast_q  <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= S_IDLE;
            end else begin
              dout_q   <= mem[rd_idx_q];
              dlast_q  <= (rd_idx_q == DEPTH_LAST);
              dvalid_q <= 1'b1;
              rd_idx_q <= rd_idx_q + AW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (wr_en && resp_extreme) begin
        sat_q <= 1'b1;
      end
    end
  end

  assign STIM   = stim_q;
  assign DOUT   = dout_q;
  assign DVALID = dvalid_q;
  assign DLAST  = dlast_q;
  assign DONE   = done_q;
  assign SAT    = sat_q;
  assign BUSY   = (state_q != S_IDLE);

endmodule

// File: doc/iir_capture.md
IIR_CAPTURE -- requirements
Module: iir_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 128, meaning the number of response samples captured per run (power of 2, 4..1024).
REQ-002 SHALL have parameter FLUSH, default 16, meaning the number of zero-stimulus cycles driven before the impulse (1..255).
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port START  input  1  run request, sampled in IDLE only.
REQ-006 SHALL have port IMP_AMP  input  16  signed impulse amplitude, latched at START acceptance.
REQ-007 SHALL have port STIM  output  16  signed stimulus to the filter cascade input, registered.
REQ-008 SHALL have port RESP  input  16  signed response from the filter cascade output.
REQ-009 SHALL have port DOUT  output  16  signed readout sample.
REQ-010 SHALL have port DVALID  output  1  DOUT holds a valid sample.
REQ-011 SHALL have port DREADY  input  1  consumer accepts DOUT.
REQ-012 SHALL have port DLAST  output  1  DOUT is sample DEPTH-1.
REQ-013 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-014 SHALL have port DONE  output  1  one-cycle pulse after the final readout transfer.
REQ-015 SHALL have port SAT  output  1  sticky flag: some captured RESP equalled +32767 or -32768.

Function
REQ-016 SHALL implement states IDLE, FLUSH, IMPULSE, CAPTURE, DRAIN.
REQ-017 In IDLE with START=1, SHALL latch IMP_AMP, clear SAT, and enter FLUSH on the same edge.
REQ-018 In FLUSH, SHALL drive STIM=0 for exactly FLUSH cycles, then enter IMPULSE.
REQ-019 In IMPULSE, SHALL drive STIM=latched IMP_AMP for exactly one cycle (cycle c0), then enter CAPTURE with STIM=0.
REQ-020 SHALL write RESP sampled at the rising edge ending cycle c0+k into mem[k], for k=0..DEPTH-1; no other samples are written.
REQ-021 SHALL hold STIM=0 throughout CAPTURE and DRAIN.
REQ-022 After mem[DEPTH-1] is written, SHALL enter DRAIN with read index 0.
REQ-023 In DRAIN, SHALL assert DVALID within 2 cycles of entry; DOUT=mem[idx]; DLAST=1 only when idx=DEPTH-1.
REQ-024 A transfer SHALL occur on an edge with DVALID=1 and DREADY=1; idx then increments.
REQ-025 While DVALID=1 and DREADY=0, DOUT, DLAST and DVALID SHALL remain stable.
REQ-026 After consecutive transfers with DREADY held high, DVALID SHALL remain high with no bubble cycles.
REQ-027 On the transfer with DLAST=1, SHALL deassert DVALID, pulse DONE on the next cycle, and return to IDLE.
REQ-028 Samples SHALL be stored and output bit-exact; no scaling, rounding or reordering.
REQ-029 SHALL set SAT when a written RESP equals 16'sh7FFF or 16'sh8000; it holds until the next accepted START.
REQ-030 SHALL ignore START outside IDLE, including START coincident with the final transfer.
REQ-031 SHALL assert DVALID only in DRAIN.
REQ-032 SHALL let DREADY be high before DVALID without consequence.

Reset
REQ-033 RST=0 SHALL immediately force IDLE, STIM=0, DOUT=0, DVALID=0, DLAST=0, BUSY=0, DONE=0, SAT=0, and clear all indices, including mid-run.
REQ-034 Memory contents need not be cleared; after reset no stale sample SHALL appear on DOUT with DVALID=1.
REQ-035 The first START SHALL be accepted on the first rising edge after RST deasserts.

Verification
REQ-036 Impulse: DEPTH=128, FLUSH=16, IMP_AMP=16384, RESP looped from STIM through a one-cycle register, DREADY=1 -> STIM=16384 exactly one cycle; DOUT sample 1 = 16384, all others 0; DLAST on 128th beat; one DONE pulse.
REQ-037 Latency check: RESP driven as a free-running counter -> captured sample k equals the counter value sampled at the edge ending c0+k; c0 is 17 cycles after START acceptance.
REQ-038 Backpressure: DREADY randomly toggled 50% -> 128 transfers in order, DOUT stable while stalled, zero loss or duplication.
REQ-039 Saturation: RESP=-32768 for one capture cycle -> SAT=1 through DRAIN; next START clears SAT.
REQ-040 Reset mid-CAPTURE and mid-DRAIN -> all outputs at reset values within the reset cycle; a new run completes correctly.
REQ-041 START pulsed during FLUSH, CAPTURE and the DLAST transfer -> ignored; exactly one run and one DONE.
